// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed, checksummed program image into RAM
module program_loader #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              prog_mode,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE
   } state_t;

   // One extra bit so a full 2^ADDR_W-byte program can be counted and compared.
   localparam logic [8:0] MAX_LEN = 9'(1 << ADDR_W);

   state_t            state_q, state_d;
   logic [8:0]        n_q, n_d;
   logic [8:0]        index_q, index_d;
   logic [7:0]        sum_q, sum_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_data_q, ram_data_d;
   logic [8:0]        index_inc;
   logic              xfer;

   assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign xfer      = in_valid && in_ready;
   assign index_inc = index_q + 9'd1;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      index_d    = index_q;
      sum_d      = sum_q;
      err_d      = err_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN;
               err_d   = 1'b0;
               index_d = '0;
               sum_d   = '0;
            end
         end
         S_LEN: begin
            if (xfer) begin
               n_d = {1'b0, in_data};
               if ((in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               ram_data_d = in_data;
               ram_addr_d = index_q[ADDR_W-1:0];
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            index_d = index_inc;
            sum_d   = sum_q + ram_data_q;
            state_d = (index_inc == n_q) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (xfer) begin
               err_d   = (in_data != sum_q);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         index_q    <= '0;
         sum_q      <= '0;
         err_q      <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         index_q    <= index_d;
         sum_q      <= sum_d;
         err_q      <= err_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_data  = ram_data_q;
   assign ram_we    = (state_q == S_WRITE);
   assign prog_mode = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven checks of program_loader loads and corner cases
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic [7:0] in_data;
   logic       in_ready, ram_we, prog_mode, done, err;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [15:0] writes[$];

   typedef struct {
      int         nbytes;
      logic [7:0] bytes [0:17];
      bit         bp;
      bit         exp_err;
      int         exp_nw;
   } vec_t;
   vec_t vec [0:5];

   program_loader #(.ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
      .prog_mode(prog_mode), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_we) writes.push_back({4'h0, ram_addr, ram_data});
      if (done) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_load(input int v, input bit noisy);
      int  idx, cyc, done0;
      bit  pm_ok, xfer;
      writes.delete();
      done0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      idx = 0; cyc = 0; pm_ok = 1'b1;
      while (idx < vec[v].nbytes && cyc < 200) begin
         if (prog_mode !== 1'b1) pm_ok = 1'b0;
         in_valid = vec[v].bp ? (cyc % 2 == 0) : 1'b1;
         in_data  = vec[v].bytes[idx];
         if (noisy) start = (cyc % 2 == 1);
         xfer = in_valid && in_ready;
         @(posedge clk);
         if (xfer) idx++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
      check($sformatf("v%0d done", v), done, 1);
      check($sformatf("v%0d prog_mode in DONE", v), prog_mode, 1);
      check($sformatf("v%0d err", v), err, vec[v].exp_err);
      @(negedge clk);
      check($sformatf("v%0d prog_mode after", v), prog_mode, 0);
      check($sformatf("v%0d done single", v), done, 0);
      check($sformatf("v%0d done count", v), done_cnt - done0, 1);
      check($sformatf("v%0d prog_mode during", v), pm_ok, 1);
      check($sformatf("v%0d write count", v), writes.size(), vec[v].exp_nw);
      for (int k = 0; k < writes.size() && k < vec[v].exp_nw; k++)
         check($sformatf("v%0d write %0d", v, k), writes[k], {8'(k), vec[v].bytes[k+1]});
   endtask

   initial begin
      vec[0].nbytes = 5; vec[0].bp = 0; vec[0].exp_err = 0; vec[0].exp_nw = 3;
      vec[0].bytes[0] = 8'h03; vec[0].bytes[1] = 8'h1E; vec[0].bytes[2] = 8'h2F;
      vec[0].bytes[3] = 8'hE0; vec[0].bytes[4] = 8'h2D;
      vec[1].nbytes = 4; vec[1].bp = 0; vec[1].exp_err = 1; vec[1].exp_nw = 2;
      vec[1].bytes[0] = 8'h02; vec[1].bytes[1] = 8'h11; vec[1].bytes[2] = 8'h22;
      vec[1].bytes[3] = 8'h00;
      vec[2].nbytes = 1; vec[2].bp = 0; vec[2].exp_err = 1; vec[2].exp_nw = 0;
      vec[2].bytes[0] = 8'h00;
      vec[3].nbytes = 1; vec[3].bp = 0; vec[3].exp_err = 1; vec[3].exp_nw = 0;
      vec[3].bytes[0] = 8'h11;
      vec[4].nbytes = 18; vec[4].bp = 1; vec[4].exp_err = 0; vec[4].exp_nw = 16;
      vec[4].bytes[0] = 8'h10; vec[4].bytes[17] = 8'h78;
      for (int i = 0; i < 16; i++) vec[4].bytes[i+1] = 8'(i);
      vec[5].nbytes = 3; vec[5].bp = 0; vec[5].exp_err = 0; vec[5].exp_nw = 1;
      vec[5].bytes[0] = 8'h01; vec[5].bytes[1] = 8'h55; vec[5].bytes[2] = 8'h55;

      // Reset wins over a simultaneous start and valid byte.
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h03;
      repeat (3) @(negedge clk);
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      check("reset prog_mode", prog_mode, 0);
      check("reset in_ready", in_ready, 0);
      check("reset ram_we", ram_we, 0);
      check("reset done", done, 0);
      check("reset err", err, 0);
      check("reset ram_addr", ram_addr, 0);
      check("reset ram_data", ram_data, 0);

      for (int v = 0; v < 6; v++) run_load(v, 1'b0);

      // err is sticky until the next accepted start.
      run_load(1, 1'b0);
      repeat (5) @(negedge clk);
      check("sticky err", err, 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("err cleared by start", err, 0);
      check("prog_mode after start", prog_mode, 1);
      in_valid = 1'b1; in_data = 8'h00; @(negedge clk); in_valid = 1'b0;
      check("len0 done", done, 1);
      check("len0 err", err, 1);
      @(negedge clk);

      // Stall with in_valid low, then reset while writing the second byte.
      writes.delete();
      begin
         int done0;
         done0 = done_cnt;
         start = 1'b1; @(negedge clk); start = 1'b0;
         in_valid = 1'b1; in_data = 8'h03; @(negedge clk);
         in_valid = 1'b0;
         repeat (5) @(negedge clk);
         check("stall in_ready", in_ready, 1);
         check("stall no write", writes.size(), 0);
         check("stall prog_mode", prog_mode, 1);
         in_valid = 1'b1; in_data = 8'hA1; @(negedge clk);
         in_data = 8'hB2; @(negedge clk);
         @(negedge clk);
         check("abort in WRITE", ram_we, 1);
         check("abort write data", ram_data, 8'hB2);
         rst = 1'b1; in_valid = 1'b0; @(negedge clk);
         check("abort ram_we", ram_we, 0);
         check("abort prog_mode", prog_mode, 0);
         check("abort ram_addr", ram_addr, 0);
         rst = 1'b0;
         repeat (3) @(negedge clk);
         check("abort no done", done_cnt - done0, 0);
         check("abort writes", writes.size(), 2);
      end
      run_load(0, 1'b0);

      // start pulses during the load are ignored.
      run_load(4, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: ADDR_W, default 4, RAM address width; maximum program length is 2^ADDR_W bytes.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 in_valid  input  1  source has a byte on in_data.
REQ-007 in_data  input  8  byte stream: length, data bytes, checksum.
REQ-008 in_ready  output  1  loader can accept in_data this cycle.
REQ-009 ram_addr  output  ADDR_W  RAM write address.
REQ-010 ram_data  output  8  RAM write data.
REQ-011 ram_we  output  1  RAM write strobe, one cycle per byte.
REQ-012 prog_mode  output  1  high while a load is in progress; holds the CPU decoder in halt.
REQ-013 done  output  1  one-cycle pulse when a load ends, successful or not.
REQ-014 err  output  1  sticky error flag for the last load.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, CSUM and DONE.
REQ-016 A byte transfers only on a cycle where in_valid and in_ready are both high.
REQ-017 in_ready SHALL be high only in LEN, DATA and CSUM; it is low in IDLE, WRITE and DONE.
REQ-018 IDLE with start=1 -> LEN, prog_mode=1, err cleared to 0, index=0, sum=0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 LEN handshake: in_data is latched as N.
REQ-021 LEN, 1 <= N <= 2^ADDR_W -> DATA.
REQ-022 LEN, N=0 or N > 2^ADDR_W -> err=1, DONE, and no RAM write SHALL occur.
REQ-023 DATA handshake -> ram_data=in_data, ram_addr=index[ADDR_W-1:0], then WRITE.
REQ-024 WRITE SHALL assert ram_we for exactly one cycle, with ram_addr and ram_data stable during that cycle.
REQ-025 In WRITE, index increments by 1 and sum = (sum + ram_data) mod 256.
REQ-026 WRITE exits to CSUM when the incremented index equals N; otherwise it returns to DATA.
REQ-027 Byte k of the data stream SHALL be written to address k-1, in order; wrap-around is impossible because N is range-checked.
REQ-028 CSUM handshake: err = (in_data != sum), then DONE.
REQ-029 DONE SHALL hold done=1 for exactly one cycle and return to IDLE; prog_mode falls to 0 on the same edge that leaves DONE.
REQ-030 While in_valid=0, the loader SHALL hold state indefinitely with no timeout; outputs stay stable.
REQ-031 ram_we SHALL be 0 in every state except WRITE.
REQ-032 err SHALL hold its value from DONE until the next accepted start.
REQ-033 A latency of one byte per two cycles (DATA+WRITE) is the maximum throughput.

Reset
REQ-034 rst=1 SHALL force on the next edge: state IDLE, prog_mode=0, in_ready=0, ram_we=0, done=0, err=0, ram_addr=0, ram_data=0, index=0, sum=0.
REQ-035 Reset mid-load SHALL abort immediately with no further writes; RAM bytes already written are not reverted, and done is not pulsed.
REQ-036 rst has priority over start and over any handshake in the same cycle.

Verification
REQ-037 Load, valid stream: start; bytes 03,1E,2F,E0, checksum 2D, in_valid held high -> writes addr0=1E, addr1=2F, addr2=E0; 3 ram_we pulses; done pulse; err=0; prog_mode high start..DONE.
REQ-038 Bad checksum: stream 02,11,22, checksum 00 (correct value 33) -> 2 writes, then done with err=1; err stays 1 until the next start.
REQ-039 Length errors: length byte 00, and separately length byte 11 (ADDR_W=4) -> no ram_we, done pulse, err=1.
REQ-040 Full program with back-pressure: length 10, 16 bytes 00..0F, checksum 78, in_valid toggled every other cycle -> 16 writes to addr 0..F in order, err=0, no byte lost or duplicated.
REQ-041 Reset abort: rst=1 asserted in WRITE after the second byte -> ram_we=0 and prog_mode=0 on the next edge, no done pulse; a following normal load succeeds.
REQ-042 start ignored: start pulses asserted while in DATA -> no state change, no err clear, and the load completes normally.
